// File: rtl/rbz_spi_cfg_ctrl_if.sv
// Bus bundle for the raybox-zero SPI configuration controller:
// raw SPI pins, the frame-boundary strobe and the live configuration outputs.
`timescale 1ns/1ps
interface rbz_spi_cfg_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
);
   localparam int NREG = 2**ADDR_W;

   logic                   i_sclk;
   logic                   i_mosi;
   logic                   i_ss_n;
   logic                   i_vsync;
   logic [NREG*DATA_W-1:0] o_cfg;
   logic                   o_busy;
   logic                   o_commit;
   logic                   o_err;

   modport slave (
      input  i_sclk, i_mosi, i_ss_n, i_vsync,
      output o_cfg, o_busy, o_commit, o_err
   );

   modport master (
      output i_sclk, i_mosi, i_ss_n, i_vsync,
      input  o_cfg, o_busy, o_commit, o_err
   );
endinterface

// File: rtl/rbz_spi_cfg_ctrl.sv
// SPI-slave register writer for the raybox-zero renderer: writes land in a shadow
// bank and are copied to the live config only on the vsync frame boundary.
`timescale 1ns/1ps
module rbz_spi_cfg_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2,
   parameter logic [(2**ADDR_W)*DATA_W-1:0] CFG_RESET = '0
) (
   input logic               clk,
   input logic               rst_n,
   rbz_spi_cfg_ctrl_if.slave bus
);
   localparam int NREG  = 2**ADDR_W;
   localparam int SH_W  = (DATA_W > 8) ? DATA_W : 8;
   localparam int CNT_W = $clog2(SH_W);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t              state;
   state_t              state_next;
   logic [2:0]          sclk_sync;
   logic [1:0]          mosi_sync;
   logic [2:0]          ss_sync;
   logic                sclk_rise;
   logic                ss_high;
   logic                ss_fall;
   logic [SH_W-2:0]     shift_q;
   logic [SH_W-1:0]     shift_d;
   logic [CNT_W-1:0]    bit_cnt;
   logic [ADDR_W-1:0]   addr;
   logic                start;
   logic                shift_en;
   logic                to_data;
   logic                wr_en;
   logic                abort;
   logic [NREG-1:0]     wr_mask;
   logic [NREG-1:0]     dirty;
   logic [DATA_W-1:0]   shadow [NREG];
   logic [DATA_W-1:0]   cfg_q  [NREG];
   logic                commit;
   logic                err;

   // Index [1] is the synchronised value; index [2] is its one-cycle-old copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], bus.i_sclk};
         mosi_sync <= {mosi_sync[0], bus.i_mosi};
         ss_sync   <= {ss_sync[1:0], bus.i_ss_n};
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign ss_high   = ss_sync[1];
   assign ss_fall   = ss_sync[2] & ~ss_sync[1];
   assign shift_d   = {shift_q, mosi_sync[1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      shift_en   = 1'b0;
      to_data    = 1'b0;
      wr_en      = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_next = CMD;
               start      = 1'b1;
            end
         end
         CMD: begin
            if (ss_high) begin
               state_next = IDLE;
               abort      = 1'b1;
            end else if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == CMD_LAST) begin
                  if (shift_d[7]) begin
                     state_next = DATA;
                     to_data    = 1'b1;
                  end else begin
                     state_next = DONE;
                  end
               end
            end
         end
         DATA: begin
            if (ss_high) begin
               state_next = IDLE;
               abort      = 1'b1;
            end else if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == DATA_LAST) begin
                  wr_en      = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (ss_high) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The counter restarts at the command/data boundary so both phases count from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bit_cnt <= '0;
         addr    <= '0;
      end else begin
         if (start) begin
            shift_q <= '0;
            bit_cnt <= '0;
         end else if (shift_en) begin
            shift_q <= shift_d[SH_W-2:0];
            bit_cnt <= to_data ? '0 : bit_cnt + CNT_W'(1);
         end
         if (to_data) addr <= shift_d[ADDR_W-1:0];
      end
   end

   assign wr_mask = wr_en ? (NREG'(1) << addr) : '0;

   // Commit reads the shadow before this cycle's write, so a colliding write stays dirty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) begin
            shadow[k] <= CFG_RESET[k*DATA_W +: DATA_W];
            cfg_q[k]  <= CFG_RESET[k*DATA_W +: DATA_W];
         end
         dirty  <= '0;
         commit <= 1'b0;
         err    <= 1'b0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (bus.i_vsync && dirty[k]) cfg_q[k] <= shadow[k];
         end
         if (wr_en) shadow[addr] <= shift_d[DATA_W-1:0];
         dirty  <= (bus.i_vsync ? '0 : dirty) | wr_mask;
         commit <= bus.i_vsync & (|dirty);
         err    <= abort;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_cfg
      assign bus.o_cfg[g*DATA_W +: DATA_W] = cfg_q[g];
   end

   assign bus.o_busy   = (state != IDLE);
   assign bus.o_commit = commit;
   assign bus.o_err    = err;
endmodule

// File: tb/tb_rbz_spi_cfg_ctrl.sv
// Bench for rbz_spi_cfg_ctrl: directed frame table, hand-timed corner sequences,
// then random frames checked against a register-level model of shadow/dirty/live banks.
`timescale 1ns/1ps
module tb_rbz_spi_cfg_ctrl;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 2;
   localparam int NREG   = 4;

   typedef struct {
      logic [39:0] bits;
      int          nbits;
      bit          vsync;
      bit          expErr;
      bit          expCommit;
      logic [63:0] expCfg;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   logic [15:0] mShadow [NREG];
   logic [15:0] mCfg    [NREG];
   bit          mDirty  [NREG];

   vec_t table_v [10];

   always #5 clk = ~clk;

   rbz_spi_cfg_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

   rbz_spi_cfg_ctrl #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .CFG_RESET(64'h0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < NREG; k++) begin
         mShadow[k] = '0;
         mCfg[k]    = '0;
         mDirty[k]  = 1'b0;
      end
   endtask

   // A frame is the first nbits of 'bits' (right-aligned, first bit sent is bits[nbits-1]).
   task automatic modelFrame(input logic [39:0] bits, input int nbits, output bit err);
      logic [7:0]  cmd;
      logic [15:0] data;
      err = 1'b0;
      if (nbits < 8) begin
         err = 1'b1;
         return;
      end
      cmd = 8'(bits >> (nbits - 8));
      if (!cmd[7]) return;
      if (nbits < 24) begin
         err = 1'b1;
         return;
      end
      data = 16'(bits >> (nbits - 24));
      mShadow[cmd[1:0]] = data;
      mDirty[cmd[1:0]]  = 1'b1;
   endtask

   task automatic modelVsync(output bit commit);
      commit = 1'b0;
      for (int k = 0; k < NREG; k++) begin
         if (mDirty[k]) begin
            mCfg[k]   = mShadow[k];
            mDirty[k] = 1'b0;
            commit    = 1'b1;
         end
      end
   endtask

   function automatic logic [63:0] modelCfg();
      return {mCfg[3], mCfg[2], mCfg[1], mCfg[0]};
   endfunction

   task automatic sendBits(input logic [39:0] bits, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.i_mosi = bits[i];
         repeat (4) @(negedge clk);
         bus.i_sclk = 1'b1;
         repeat (4) @(negedge clk);
         bus.i_sclk = 1'b0;
      end
   endtask

   task automatic closeFrame(input bit expBusy, output int errCount);
      checkOutput("busy_in_frame", 64'(bus.o_busy), 64'(expBusy));
      bus.i_ss_n = 1'b1;
      errCount = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.o_err) errCount++;
      end
      checkOutput("busy_after_frame", 64'(bus.o_busy), 64'h0);
   endtask

   task automatic applyStimulus(input logic [39:0] bits, input int nbits, output int errCount);
      @(negedge clk);
      bus.i_ss_n = 1'b0;
      repeat (4) @(negedge clk);
      sendBits(bits, nbits);
      repeat (4) @(negedge clk);
      closeFrame(1'b1, errCount);
   endtask

   task automatic vsyncPulse(input bit expCommit, input logic [63:0] expCfg, input string tag);
      @(negedge clk);
      bus.i_vsync = 1'b1;
      @(negedge clk);
      bus.i_vsync = 1'b0;
      checkOutput({tag, "_commit"}, 64'(bus.o_commit), 64'(expCommit));
      checkOutput({tag, "_cfg"}, bus.o_cfg, expCfg);
      @(negedge clk);
      checkOutput({tag, "_commit_width"}, 64'(bus.o_commit), 64'h0);
   endtask

   initial begin
      int errCnt;
      bit mErr;
      bit mCommit;

      // Frame, bit count, vsync after, expected err pulse, expected commit, expected live bank.
      table_v[0] = '{40'h81_1234,      24, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0000};
      table_v[1] = '{40'h0,             0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_1234_0000};
      table_v[2] = '{40'h0,             0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_1234_0000};
      table_v[3] = '{40'h01_FFFF,      24, 1'b1, 1'b0, 1'b0, 64'h0000_0000_1234_0000};
      table_v[4] = '{40'h20A,          10, 1'b1, 1'b1, 1'b0, 64'h0000_0000_1234_0000};
      table_v[5] = '{40'h82_BEEF,      24, 1'b1, 1'b0, 1'b1, 64'h0000_BEEF_1234_0000};
      table_v[6] = '{40'h83_0007_FFFF, 40, 1'b1, 1'b0, 1'b1, 64'h0007_BEEF_1234_0000};
      table_v[7] = '{40'h81_1111,      24, 1'b0, 1'b0, 1'b0, 64'h0007_BEEF_1234_0000};
      table_v[8] = '{40'h81_2222,      24, 1'b1, 1'b0, 1'b1, 64'h0007_BEEF_2222_0000};
      table_v[9] = '{40'h80_AAAA,      24, 1'b0, 1'b0, 1'b0, 64'h0007_BEEF_2222_0000};

      modelReset();
      bus.i_sclk  = 1'b0;
      bus.i_mosi  = 1'b0;
      bus.i_ss_n  = 1'b1;
      bus.i_vsync = 1'b0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_cfg", bus.o_cfg, 64'h0);
      checkOutput("reset_busy", 64'(bus.o_busy), 64'h0);
      checkOutput("reset_commit", 64'(bus.o_commit), 64'h0);
      checkOutput("reset_err", 64'(bus.o_err), 64'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         if (table_v[i].nbits > 0) begin
            applyStimulus(table_v[i].bits, table_v[i].nbits, errCnt);
            modelFrame(table_v[i].bits, table_v[i].nbits, mErr);
            checkOutput($sformatf("vec%0d_err", i), 64'(errCnt), 64'(table_v[i].expErr));
         end
         if (table_v[i].vsync) begin
            modelVsync(mCommit);
            vsyncPulse(table_v[i].expCommit, table_v[i].expCfg, $sformatf("vec%0d", i));
         end else begin
            checkOutput($sformatf("vec%0d_cfg", i), bus.o_cfg, table_v[i].expCfg);
         end
      end

      // Collision: the final data bit of 0x80,0x55,0x55 completes in the same cycle vsync is high.
      @(negedge clk);
      bus.i_ss_n = 1'b0;
      repeat (4) @(negedge clk);
      sendBits(40'h40_2AAA, 23);
      bus.i_mosi = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_sclk = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_vsync = 1'b1;
      @(negedge clk);
      bus.i_vsync = 1'b0;
      modelVsync(mCommit);
      modelFrame(40'h80_5555, 24, mErr);
      checkOutput("collide_cfg", bus.o_cfg, 64'h0007_BEEF_2222_AAAA);
      checkOutput("collide_commit", 64'(bus.o_commit), 64'h1);
      repeat (2) @(negedge clk);
      bus.i_sclk = 1'b0;
      repeat (4) @(negedge clk);
      closeFrame(1'b1, errCnt);
      checkOutput("collide_err", 64'(errCnt), 64'h0);
      modelVsync(mCommit);
      vsyncPulse(1'b1, 64'h0007_BEEF_2222_5555, "collide_next");
      modelVsync(mCommit);
      vsyncPulse(1'b0, 64'h0007_BEEF_2222_5555, "collide_idle");

      // Reset mid-DATA with reg3 still dirty: nothing may survive, and the held-low ss_n must not restart a frame.
      applyStimulus(40'h83_1234, 24, errCnt);
      checkOutput("pre_reset_err", 64'(errCnt), 64'h0);
      @(negedge clk);
      bus.i_ss_n = 1'b0;
      repeat (4) @(negedge clk);
      sendBits(40'h815, 12);
      checkOutput("mid_data_busy", 64'(bus.o_busy), 64'h1);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("midrst_cfg", bus.o_cfg, 64'h0);
      checkOutput("midrst_busy", 64'(bus.o_busy), 64'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sendBits(40'hA5, 8);
      closeFrame(1'b0, errCnt);
      checkOutput("midrst_err", 64'(errCnt), 64'h0);
      vsyncPulse(1'b0, 64'h0, "midrst_vsync");
      applyStimulus(40'h82_CAFE, 24, errCnt);
      modelFrame(40'h82_CAFE, 24, mErr);
      checkOutput("resume_err", 64'(errCnt), 64'h0);
      modelVsync(mCommit);
      vsyncPulse(1'b1, 64'h0000_CAFE_0000_0000, "resume");

      for (int n = 0; n < 40; n++) begin
         logic [7:0]  cmd;
         logic [39:0] raw;
         logic [39:0] bits;
         int          nbits;
         int          kind;
         cmd  = {($urandom_range(0, 3) != 0), 5'($urandom), 2'($urandom)};
         raw  = {cmd, 16'($urandom), 16'($urandom)};
         kind = int'($urandom_range(0, 9));
         if (kind < 7)       nbits = 24;
         else if (kind == 7) nbits = int'($urandom_range(1, 23));
         else                nbits = int'($urandom_range(25, 40));
         bits = raw >> (40 - nbits);
         applyStimulus(bits, nbits, errCnt);
         modelFrame(bits, nbits, mErr);
         checkOutput($sformatf("rand%0d_err", n), 64'(errCnt), 64'(mErr));
         if ($urandom_range(0, 1) == 1) begin
            modelVsync(mCommit);
            vsyncPulse(mCommit, modelCfg(), $sformatf("rand%0d", n));
         end else begin
            checkOutput($sformatf("rand%0d_cfg", n), bus.o_cfg, modelCfg());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
